// File: rtl/gf180mcu_norn_pkg.sv
// Shared constants and elaboration helpers for the pipelined NOR-reduction register.
//   RADIX    : fan-in of every reduction register
//   HOLD_MAX : largest supported HOLD
//   clog4    : number of tree levels for a given input width (at least 1)
//   groups   : register count at a given level (level 0 = raw input width)
package gf180mcu_norn_pkg;

    localparam int unsigned RADIX    = 4;
    localparam int unsigned HOLD_MAX = 255;

    function automatic int unsigned clog4(input int unsigned n);
        int unsigned l;
        int unsigned cap;
        l   = 1;
        cap = RADIX;
        // Eight steps cover widths far beyond the legal 1024 maximum.
        for (int i = 0; i < 8; i++) begin
            if (cap < n) begin
                l   = l + 1;
                cap = cap * RADIX;
            end
        end
        return l;
    endfunction

    function automatic int unsigned groups(input int unsigned n, input int unsigned level);
        int unsigned g;
        g = n;
        for (int unsigned i = 0; i < level; i++) begin
            g = (g + RADIX - 1) / RADIX;
        end
        return g;
    endfunction

endpackage

// File: rtl/gf180mcu_norn_level.sv
// One registered radix-4 reduction level.
//   FIRST=1 : each output is NOR4 of its group, short group padded with 0
//   FIRST=0 : each output is AND4 of its group, short group padded with 1
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_bits    : IN_W bits from the previous level (or the sampled input)
//   out_q      : ceil(IN_W/4) registered results
module gf180mcu_norn_level
    import gf180mcu_norn_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter bit          FIRST = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [IN_W-1:0]                        in_bits,
    output logic [(IN_W + RADIX - 1) / RADIX - 1:0] out_q
);

    localparam int unsigned OUT_W = (IN_W + RADIX - 1) / RADIX;
    localparam int unsigned PAD_W = OUT_W * RADIX;

    logic [PAD_W-1:0] pad_v;
    logic [OUT_W-1:0] out_d;

    // Pad to a whole number of groups with the reduction's neutral value.
    always_comb begin
        pad_v = FIRST ? '0 : '1;
        pad_v[IN_W-1:0] = in_bits;
        out_d = '0;
        for (int unsigned g = 0; g < OUT_W; g++) begin
            out_d[g] = FIRST ? ~(|pad_v[g*RADIX +: RADIX]) : (&pad_v[g*RADIX +: RADIX]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_norn_reg.sv
// Pipelined WIDTH-input NOR with valid qualifier and zero-run stable flag.
// Optional build macro: GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN adds mask port M
// (bit excluded when M[i]=1).
// Ports:
//   CLK    : rising-edge clock
//   RN     : asynchronous active-low reset
//   EN     : sample valid, A (and M) captured when 1
//   A      : data to reduce
//   M      : per-bit exclusion mask (mask build only)
//   ZN     : registered NOR of the last valid sample
//   ZN_VLD : one-cycle pulse when ZN was updated
//   ZN_STB : ZN has been 1 for HOLD consecutive valid results
module gf180mcu_fd_sc_mcu9t5v0_norn_reg
    import gf180mcu_norn_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned HOLD  = 3
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
    input  logic [WIDTH-1:0] M,
`endif
    output logic             ZN,
    output logic             ZN_VLD,
    output logic             ZN_STB
);

    localparam int unsigned LEVELS = clog4(WIDTH);
    localparam int unsigned RC_W   = $clog2(HOLD + 1);

    logic [WIDTH-1:0]  a_s;
    logic              tree_res;
    logic [LEVELS-1:0] vld_q, vld_d;
    logic              zn_q, zn_d;
    logic              zn_vld_q, zn_vld_d;
    logic              zn_stb_q, zn_stb_d;
    logic [RC_W-1:0]   rc_q, rc_d;

    // Force idle samples to zero so undriven A never propagates into the tree.
    always_comb begin
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
        a_s = EN ? (A & ~M) : '0;
`else
        a_s = EN ? A : '0;
`endif
    end

    // Reduction tree: first level NOR4, upper levels AND4 of the NOR results.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned IW = groups(WIDTH, l);
        localparam int unsigned OW = groups(WIDTH, l + 1);
        logic [IW-1:0] lvl_in;
        logic [OW-1:0] lvl_out;

        if (l == 0) begin : g_first
            assign lvl_in = a_s;
        end else begin : g_rest
            assign lvl_in = g_lvl[l-1].lvl_out;
        end

        gf180mcu_norn_level #(
            .IN_W  (IW),
            .FIRST ((l == 0) ? 1'b1 : 1'b0)
        ) u_lvl (
            .clk     (CLK),
            .rst_n   (RN),
            .in_bits (lvl_in),
            .out_q   (lvl_out)
        );
    end

    assign tree_res = g_lvl[LEVELS-1].lvl_out[0];

    // Valid pipeline tracks EN alongside the tree; output stage and run counter.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = EN;
        zn_d     = zn_q;
        zn_vld_d = vld_q[LEVELS-1];
        rc_d     = rc_q;
        if (vld_q[LEVELS-1]) begin
            zn_d = tree_res;
            if (tree_res) begin
                rc_d = (rc_q == RC_W'(HOLD)) ? rc_q : rc_q + RC_W'(1);
            end else begin
                rc_d = '0;
            end
        end
        // Computed from the next count so STB lands with the completing ZN.
        zn_stb_d = (rc_d == RC_W'(HOLD));
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            vld_q    <= '0;
            zn_q     <= 1'b0;
            zn_vld_q <= 1'b0;
            zn_stb_q <= 1'b0;
            rc_q     <= '0;
        end else begin
            vld_q    <= vld_d;
            zn_q     <= zn_d;
            zn_vld_q <= zn_vld_d;
            zn_stb_q <= zn_stb_d;
            rc_q     <= rc_d;
        end
    end

    assign ZN     = zn_q;
    assign ZN_VLD = zn_vld_q;
    assign ZN_STB = zn_stb_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_norn_reg.sv
// Scoreboard bench for the pipelined NOR register (WIDTH=16/HOLD=3 plus a WIDTH=17 instance).
module tb_gf180mcu_fd_sc_mcu9t5v0_norn_reg;

    localparam int unsigned W      = 16;
    localparam int unsigned H      = 3;
    localparam int unsigned LAT    = 2;
    localparam int unsigned LAT17  = 3;

    logic          CLK = 1'b0;
    logic          RN;
    logic          EN;
    logic [W-1:0]  A;
    logic          ZN, ZN_VLD, ZN_STB;
    logic          EN17;
    logic [16:0]   A17;
    logic          ZN17, ZN_VLD17, ZN_STB17;
    logic [W-1:0]  mm;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
    logic [W-1:0]  M;
    logic [16:0]   M17;
`endif

    typedef struct {
        int unsigned cyc;
        logic        zn;
        logic        stb;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned vec = 0;
    int unsigned err = 0;
    int unsigned rc_m = 0;
    logic        last_zn = 1'b0;
    logic        last_stb = 1'b0;
    bit          mon_on = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    gf180mcu_fd_sc_mcu9t5v0_norn_reg #(.WIDTH(W), .HOLD(H)) dut (
        .CLK    (CLK),
        .RN     (RN),
        .EN     (EN),
        .A      (A),
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
        .M      (M),
`endif
        .ZN     (ZN),
        .ZN_VLD (ZN_VLD),
        .ZN_STB (ZN_STB)
    );

    gf180mcu_fd_sc_mcu9t5v0_norn_reg #(.WIDTH(17), .HOLD(2)) dut17 (
        .CLK    (CLK),
        .RN     (RN),
        .EN     (EN17),
        .A      (A17),
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
        .M      (M17),
`endif
        .ZN     (ZN17),
        .ZN_VLD (ZN_VLD17),
        .ZN_STB (ZN_STB17)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vec++;
        if (act !== exp_v) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Drive one cycle of stimulus; a valid sample queues its expected result.
    task automatic issue(input logic en, input logic [W-1:0] a);
        exp_t e;
        logic z;
        @(negedge CLK);
        EN = en;
        A  = a;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
        M  = mm;
`endif
        if (en) begin
            z = ((a & ~mm) == '0);
            if (z) rc_m = (rc_m < H) ? rc_m + 1 : H;
            else   rc_m = 0;
            e.cyc = cyc + 1 + LAT;
            e.zn  = z;
            e.stb = (rc_m == H);
            q.push_back(e);
        end
    endtask

    // Monitor: every cycle either a queued result is due or outputs must hold.
    always @(negedge CLK) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("zn_vld", 32'(ZN_VLD), 32'd1);
                chk("zn", 32'(ZN), 32'(e.zn));
                chk("zn_stb", 32'(ZN_STB), 32'(e.stb));
                last_zn  = e.zn;
                last_stb = e.stb;
            end else begin
                chk("zn_vld_idle", 32'(ZN_VLD), 32'd0);
                chk("zn_hold", 32'(ZN), 32'(last_zn));
                chk("zn_stb_hold", 32'(ZN_STB), 32'(last_stb));
            end
        end
    end

    // Reset asserted mid-cycle for one clock while samples are in flight.
    task automatic pulse_reset();
        @(negedge CLK);
        EN = 1'b0;
        #2;
        RN = 1'b0;
        q.delete();
        rc_m     = 0;
        last_zn  = 1'b0;
        last_stb = 1'b0;
        #1;
        chk("rst_zn", 32'(ZN), 32'd0);
        chk("rst_vld", 32'(ZN_VLD), 32'd0);
        chk("rst_stb", 32'(ZN_STB), 32'd0);
        @(negedge CLK);
        RN = 1'b1;
    endtask

    // WIDTH=17 latency and result check with a bounded wait.
    task automatic t17(input logic [16:0] a, input logic exp_zn);
        int unsigned n;
        bit          got;
        @(negedge CLK);
        EN17 = 1'b1;
        A17  = a;
        @(negedge CLK);
        EN17 = 1'b0;
        A17  = '0;
        n    = 1;
        got  = 1'b0;
        while (n < 10 && !got) begin
            if (ZN_VLD17) got = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        chk("lat17", 32'(n - 1), 32'(LAT17));
        chk("zn17", 32'(ZN17), 32'(exp_zn));
    endtask

    initial begin
        RN   = 1'b0;
        EN   = 1'b0;
        A    = '0;
        EN17 = 1'b0;
        A17  = '0;
        mm   = '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
        M    = '0;
        M17  = '0;
`endif
        repeat (2) @(negedge CLK);
        chk("init_zn", 32'(ZN), 32'd0);
        chk("init_vld", 32'(ZN_VLD), 32'd0);
        chk("init_stb", 32'(ZN_STB), 32'd0);
        RN = 1'b1;
        mon_on = 1'b1;

        // Single all-zero sample.
        issue(1'b1, '0);
        repeat (4) issue(1'b0, W'($urandom));

        // Zero run reaching HOLD, then a non-zero breaks it.
        repeat (3) issue(1'b1, '0);
        issue(1'b1, 16'h0100);
        repeat (3) issue(1'b0, '0);

        // Valid zeros interleaved with all-ones bubbles.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, '0);
            issue(1'b0, 16'hFFFF);
        end

        // Every single-hot input.
        for (int i = 0; i < W; i++) issue(1'b1, W'(1) << i);

        // Randomised traffic biased toward zero and sparse inputs.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a;
            case ($urandom_range(0, 3))
                0, 3:    a = '0;
                1:       a = W'(1) << $urandom_range(0, W - 1);
                default: a = W'($urandom);
            endcase
`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
            mm = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
`endif
            issue($urandom_range(0, 3) != 0, a);
        end
        mm = '0;

        // Reset with two samples still in the pipeline.
        issue(1'b1, '0);
        issue(1'b1, 16'h0010);
        pulse_reset();
        repeat (4) issue(1'b0, '0);
        repeat (4) issue(1'b1, '0);

`ifdef GF180MCU_FD_SC_MCU9T5V0_NORN_MASK_EN
        mm = 16'h8001;
        issue(1'b1, 16'h8001);
        mm = 16'h8000;
        issue(1'b1, 16'h8001);
        mm = 16'hFFFF;
        issue(1'b1, 16'hFFFF);
        mm = '0;
`endif

        repeat (LAT + 4) issue(1'b0, '0);
        chk("drain", 32'(q.size()), 32'd0);

        t17(17'h10000, 1'b0);
        t17(17'h00000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
